// File: rtl/color_event_fifo.sv
// color_event_fifo
// Captures colour-change events from the upstream detector, encodes the sampled
// RGB lines into a 2-bit colour code and queues the codes in a small FIFO.
// A saturating event counter and a sticky overflow flag are kept alongside.
// The read side pops one entry per accepted RdEn and presents it on RdData
// one cycle later, marked by a single-cycle RdValid pulse.

module color_event_fifo #(
   parameter int DEPTH = 8,   // FIFO entries, power of 2, >= 2
   parameter int AW    = 3,   // log2(DEPTH)
   parameter int CW    = 8    // EventCount width
) (
   input  logic          Clock,
   input  logic          Reset,       // asynchronous, active-low
   input  logic          NewColor,
   input  logic          Red,
   input  logic          Green,
   input  logic          Blue,
   input  logic          Clear,       // synchronous clear, highest priority
   input  logic          RdEn,
   output logic [1:0]    RdData,
   output logic          RdValid,
   output logic          Empty,
   output logic          Full,
   output logic [AW:0]   Level,
   output logic [CW-1:0] EventCount,
   output logic          Overflow
);

   // Colour codes stored in the FIFO; anything not one-hot is kept as INVALID.
   typedef enum logic [1:0] {
      CODE_INVALID = 2'd0,
      CODE_RED     = 2'd1,
      CODE_GREEN   = 2'd2,
      CODE_BLUE    = 2'd3
   } color_code_e;

   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   // Storage and state
   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
   logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
   logic [AW:0]   level_q,     level_d;
   logic [CW-1:0] count_q,     count_d;
   logic          overflow_q,  overflow_d;
   logic [1:0]    rd_data_q,   rd_data_d;
   logic          rd_valid_q,  rd_valid_d;

   // Decoded per-cycle controls
   color_code_e   color_code;
   logic          empty;
   logic          full;
   logic          rd_accept;
   logic          wr_accept;

   assign empty = (level_q == '0);
   assign full  = (level_q == LVL_FULL);

   // Encode the sampled colour lines; only a single active line is a valid colour.
   always_comb begin
      unique case ({Red, Green, Blue})
         3'b100:  color_code = CODE_RED;
         3'b010:  color_code = CODE_GREEN;
         3'b001:  color_code = CODE_BLUE;
         default: color_code = CODE_INVALID;
      endcase
   end

   // Accept decisions: Clear discards both sides; a write into a full FIFO
   // succeeds only when the same-cycle read frees a slot. A read is never
   // accepted while empty, so an empty FIFO does not fall through.
   always_comb begin
      rd_accept = RdEn && !empty && !Clear;
      wr_accept = NewColor && !Clear && (!full || rd_accept);
   end

   // Next-state computation for pointers, level, counter, flags and read port.
   // NOTE: every variable gets a default first so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;

      if (Clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (NewColor && !wr_accept) begin
            overflow_d = 1'b1;
         end
         if (NewColor && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
         end
         if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
         end
         unique case ({wr_accept, rd_accept})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   // Control state register with asynchronous active-low reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rd_data_q  <= 2'b00;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Entry storage; a simultaneous read of the same slot sees the old value.
   // NOTE: the array has no reset; its contents are only observable after a
   // write, so resetting it would just add reset fan-out to every bit.
   always_ff @(posedge Clock) begin
      if (wr_accept) begin
         mem[wr_ptr_q] <= color_code;
      end
   end

   assign RdData     = rd_data_q;
   assign RdValid    = rd_valid_q;
   assign Empty      = empty;
   assign Full       = full;
   assign Level      = level_q;
   assign EventCount = count_q;
   assign Overflow   = overflow_q;

endmodule
